// File: rtl/rf_seq_pkg.sv
// rf_op_sequencer shared definitions: opcodes, FSM states, width defaults.
// Used by ula_core and rf_op_sequencer.
package rf_seq_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_PASS = 3'b101,
    OP_LOAD = 3'b110,
    OP_NOT  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_EXEC,
    S_WB,
    S_DONE,
    S_VFY_RD,
    S_VFY_CMP
  } state_e;

endpackage

// File: rtl/ula_core.sv
// Combinational ULA: y = op(a, b), carry-out for ADD/SUB.
// LOAD passes b through so the immediate shares the write path.
module ula_core
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_e               op,
  output logic [DATA_W-1:0] y,
  output logic              carry
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    unique case (op)
      OP_ADD:  {carry, y} = sum;
      OP_SUB:  {carry, y} = dif;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_PASS: y = a;
      OP_LOAD: y = b;
      OP_NOT:  y = ~a;
    endcase
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// Register-file op sequencer: read A, read B, compute, write back.
// RF_SEQ_READBACK_EN adds a read-back verify of the written register.
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic [DATA_W-1:0] load_data,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              mismatch
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] src_b_q, src_b_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              rf_we_q, rf_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              mm_q, mm_d;

  logic              idle;
  logic              wb_go;
  op_e               ula_op;
  logic [DATA_W-1:0] ula_b;
  logic [DATA_W-1:0] ula_y;
  logic              ula_c;

  // LOAD goes straight from IDLE to WB, so the ULA sees the live command.
  assign idle   = (state_q == S_IDLE);
  assign ula_op = idle ? op_e'(op) : op_q;
  assign ula_b  = idle ? load_data : rf_rdata;

  ula_core #(.DATA_W(DATA_W)) u_ula (
    .a     (a_q),
    .b     (ula_b),
    .op    (ula_op),
    .y     (ula_y),
    .carry (ula_c)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_b_d    = src_b_q;
    dst_d      = dst_q;
    rf_addr_d  = rf_addr_q;
    a_d        = a_q;
    rf_wdata_d = rf_wdata_q;
    result_d   = result_q;
    rf_we_d    = 1'b0;
    done_d     = 1'b0;
    carry_d    = carry_q;
    zero_d     = zero_q;
    mm_d       = mm_q;
    wb_go      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          src_b_d = src_b;
          dst_d   = dst;
          if (op_e'(op) == OP_LOAD) begin
            state_d   = S_WB;
            rf_addr_d = dst;
            wb_go     = 1'b1;
          end else begin
            state_d   = S_RD_A;
            rf_addr_d = src_a;
          end
        end
      end
      S_RD_A: begin
        state_d   = S_RD_B;
        rf_addr_d = src_b_q;
      end
      S_RD_B: begin
        state_d   = S_EXEC;
        rf_addr_d = dst_q;
        a_d       = rf_rdata;
      end
      S_EXEC: begin
        state_d = S_WB;
        wb_go   = 1'b1;
      end
      S_WB: begin
`ifdef RF_SEQ_READBACK_EN
        state_d = S_VFY_RD;
`else
        state_d = S_DONE;
        done_d  = 1'b1;
`endif
      end
      S_VFY_RD: state_d = S_VFY_CMP;
      S_VFY_CMP: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        mm_d    = (rf_rdata != result_q);
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (wb_go) begin
      rf_we_d    = 1'b1;
      rf_wdata_d = ula_y;
      result_d   = ula_y;
      carry_d    = ula_c;
      zero_d     = (ula_y == '0);
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_ADD;
      src_b_q    <= '0;
      dst_q      <= '0;
      rf_addr_q  <= '0;
      a_q        <= '0;
      rf_wdata_q <= '0;
      result_q   <= '0;
      rf_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      mm_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src_b_q    <= src_b_d;
      dst_q      <= dst_d;
      rf_addr_q  <= rf_addr_d;
      a_q        <= a_d;
      rf_wdata_q <= rf_wdata_d;
      result_q   <= result_d;
      rf_we_q    <= rf_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      mm_q       <= mm_d;
    end
  end

  assign rf_addr  = rf_addr_q;
  assign rf_we    = rf_we_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign mismatch = mm_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Bench for rf_op_sequencer: 4x4 register-file model plus arithmetic reference.
// Honours RF_SEQ_READBACK_EN for the verify timing and corrupted read-back case.
module tb_rf_op_sequencer;

`ifdef RF_SEQ_READBACK_EN
  localparam int XTRA = 2;
`else
  localparam int XTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [1:0] src_a, src_b, dst;
  logic [3:0] load_data;
  logic [1:0] rf_addr;
  logic       rf_we;
  logic [3:0] rf_wdata;
  logic [3:0] rf_rdata;
  logic       busy, done, result_c, carry, zero, mismatch;
  logic [3:0] result;

  logic [3:0] mem [4];
  logic [3:0] seed [4];
  logic [3:0] mref [4];
  logic       load_seed = 1'b0;
  logic       corrupt = 1'b0;
  logic       we_d1 = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rf_op_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .dst       (dst),
    .load_data (load_data),
    .rf_addr   (rf_addr),
    .rf_we     (rf_we),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .mismatch  (mismatch)
  );

  assign result_c = 1'b0;

  // Register file: 1-cycle read latency, not reset. The first read after a
  // write can be corrupted to exercise the read-back check.
  always @(posedge clk) begin
    we_d1 <= rf_we;
    if (load_seed) begin
      for (int i = 0; i < 4; i++) mem[i] <= seed[i];
    end else if (rf_we) begin
      mem[rf_addr] <= rf_wdata;
    end else begin
      rf_rdata <= mem[rf_addr] ^ ((corrupt && we_d1) ? 4'h1 : 4'h0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: {carry, y} from plain integer arithmetic on 4-bit values.
  function automatic logic [4:0] ref_op(input int o, input int a,
                                        input int b, input int ld);
    int s;
    case (o)
      0: s = a + b;
      1: s = a + (15 - b) + 1;
      2: s = a & b;
      3: s = a | b;
      4: s = a ^ b;
      5: s = a;
      6: s = ld;
      default: s = 15 - a;
    endcase
    return 5'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [2:0] o, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [1:0] d,
                         input logic [3:0] ld, input logic exp_mm);
    logic [4:0] e;
    logic [7:0] addrs;
    logic [3:0] wd;
    int wb_c, done_c, nwe, wc, dc, nd;
    e      = ref_op(int'(o), int'(mref[sa]), int'(mref[sb]), int'(ld));
    wb_c   = (o == 3'd6) ? 1 : 4;
    done_c = wb_c + 1 + XTRA;
    start = 1'b1; op = o; src_a = sa; src_b = sb; dst = d; load_data = ld;
    nwe = 0; wc = -1; dc = -1; nd = 0; addrs = '0; wd = '0;
    for (int c = 1; c <= done_c + 1; c++) begin
      tick();
      if (c == 1) begin
        start = 1'b0;
        chk("busy_c1", busy, 1);
      end
      if (rf_we) begin nwe++; wc = c; wd = rf_wdata; end
      if (done) begin nd++; dc = c; end
      if (c <= 4) addrs = {addrs[5:0], rf_addr};
    end
    mref[d] = e[3:0];
    chk("we_count", nwe, 1);
    chk("we_cycle", wc, wb_c);
    chk("done_count", nd, 1);
    chk("done_cycle", dc, done_c);
    chk("wdata", wd, e[3:0]);
    chk("result", result, e[3:0]);
    chk("carry", carry, e[4]);
    chk("zero", zero, e[3:0] == 4'h0);
    chk("rf_mem", mem[d], mref[d]);
    chk("busy_idle", busy, 0);
    chk("mismatch", mismatch, exp_mm);
    if (o != 3'd6) chk("addr_seq", addrs, {sa, sb, d, d});
  endtask

  initial begin
    logic [4:0] e;
    int acc [$];
    int nwe, nd, prev_busy, per;
    reset = 1'b0; start = 1'b0; op = '0;
    src_a = '0; src_b = '0; dst = '0; load_data = '0;
    for (int i = 0; i < 4; i++) begin
      seed[i] = 4'($urandom);
      mref[i] = seed[i];
    end
    load_seed = 1'b1;
    tick();
    load_seed = 1'b0;
    tick();
    chk("reset_outs",
        {rf_addr, rf_we, rf_wdata, busy, done, result, carry, zero, mismatch},
        0);
    reset = 1'b1;
    tick();

    // Directed sequence from the plan
    run_cmd(3'd6, 2'd1, 2'd0, 2'd1, 4'h3, 1'b0);
    chk("load_r1", result, 4'h3);
    run_cmd(3'd6, 2'd2, 2'd0, 2'd2, 4'h5, 1'b0);
    chk("load_r2", result, 4'h5);
    run_cmd(3'd0, 2'd1, 2'd2, 2'd3, 4'h0, 1'b0);
    chk("add_r3", mem[3], 4'h8);
    run_cmd(3'd1, 2'd1, 2'd2, 2'd0, 4'h0, 1'b0);
    chk("sub_r0", {carry, mem[0]}, 5'h0E);
    run_cmd(3'd6, 2'd0, 2'd0, 2'd0, 4'hF, 1'b0);
    run_cmd(3'd6, 2'd1, 2'd0, 2'd1, 4'h1, 1'b0);
    run_cmd(3'd0, 2'd0, 2'd1, 2'd2, 4'h0, 1'b0);
    chk("add_wrap", {carry, zero, result}, 6'h30);
    run_cmd(3'd4, 2'd3, 2'd3, 2'd3, 4'h0, 1'b0);

    // start held for 10 cycles: two commands accepted
    start = 1'b1; op = 3'd0; src_a = 2'd3; src_b = 2'd1; dst = 2'd2;
    load_data = '0;
    per = 6 + XTRA;
    nwe = 0; nd = 0; prev_busy = 0;
    for (int c = 1; c <= 2 * per; c++) begin
      tick();
      if (c == 10) start = 1'b0;
      if (busy && prev_busy == 0) acc.push_back(c - 1);
      prev_busy = int'(busy);
      if (rf_we) nwe++;
      if (done) nd++;
    end
    for (int k = 0; k < 2; k++) begin
      e = ref_op(0, int'(mref[3]), int'(mref[1]), 0);
      mref[2] = e[3:0];
    end
    chk("hold_accepts", acc.size(), 2);
    if (acc.size() == 2) begin
      chk("hold_acc0", acc[0], 0);
      chk("hold_acc1", acc[1], per);
    end
    chk("hold_we", nwe, 2);
    chk("hold_done", nd, 2);
    chk("hold_mem", mem[2], mref[2]);

    // Reset asserted in EXEC aborts the write
    start = 1'b1; op = 3'd1; src_a = 2'd0; src_b = 2'd1; dst = 2'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_outs",
        {rf_addr, rf_we, rf_wdata, busy, done, result, carry, zero, mismatch},
        0);
    chk("rst_dst", mem[3], mref[3]);
    reset = 1'b1;
    tick();
    run_cmd(3'd3, 2'd0, 2'd2, 2'd3, 4'h0, 1'b0);

`ifdef RF_SEQ_READBACK_EN
    corrupt = 1'b1;
    run_cmd(3'd0, 2'd1, 2'd2, 2'd0, 4'h0, 1'b1);
    corrupt = 1'b0;
    run_cmd(3'd0, 2'd1, 2'd2, 2'd0, 4'h0, 1'b0);
`endif

    // Randomized commands against the reference model
    for (int n = 0; n < 24; n++) begin
      run_cmd(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom),
              2'($urandom), 4'($urandom), 1'b0);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rf_op_sequencer.md
# rf_op_sequencer

Initiator side of the 4×4 register-file access interface: accepts one operation command, reads the source operands over the file's single shared address port, computes the result in a small ULA, and writes the result back to the destination register. It sits between the datapath control (command source) and the register file, and is the only block that drives the register file's `addr`, `we` and `data_in`.

## Interface
- `DATA_W`, default 4: word width. Must match the register file.
- `ADDR_W`, default 2: register address width, giving 4 registers.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `op`  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASS_A, 110 LOAD, 111 NOT_A.
- `src_a`, `src_b`, `dst`  in  ADDR_W each  operand and destination addresses.
- `load_data`  in  DATA_W  immediate value for LOAD.
- `rf_addr`  out  ADDR_W  to register-file `addr`.
- `rf_we`  out  1  to register-file `we`.
- `rf_wdata`  out  DATA_W  to register-file `data_in`.
- `rf_rdata`  in  DATA_W  from register-file `data_out`.
- `busy`  out  1  command in flight.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  DATA_W  last written value, held.
- `carry`, `zero`  out  1 each  flags of the last op, held.
- `mismatch`  out  1  read-back failure; see Configuration.

## Operation
- All outputs are registered. Per-state values below are those driven during that state's cycle.
- Reset (`reset`=0 at an edge): go to IDLE. Every output clears to 0, including `rf_we`, `rf_addr`, `rf_wdata` and the flags. Reset applies in any state, mid-operation included. A write that has not yet reached WB never happens. The register file itself is not reset.
- IDLE: `busy`=0, `rf_we`=0. On `start`=1, latch `op`/`src_a`/`src_b`/`dst`/`load_data`. Next state is WB if `op`=LOAD, otherwise RD_A.
- RD_A: `rf_addr`=`src_a`, `rf_we`=0. The file captures R[src_a] at the end of this cycle.
- RD_B: `rf_addr`=`src_b`, `rf_we`=0. Capture `rf_rdata` into operand A.
- EXEC: `rf_addr`=`dst`, `rf_we`=0. Capture `rf_rdata` into operand B.
- WB: `rf_addr`=`dst`, `rf_we`=1, `rf_wdata`=ULA(A,B), or `load_data` for LOAD. Update `result`, `carry` and `zero` in the same cycle.
- DONE: `done`=1, `rf_we`=0. Next state is IDLE.
- `busy`=1 in every state except IDLE. `start` is ignored while busy, including during DONE.
- Arithmetic is modulo 2^DATA_W.
  - ADD: `carry` = carry-out.
  - SUB: computed as A + ~B + 1, and `carry` is that carry-out (1 means no borrow).
  - Logic ops, PASS_A, NOT_A and LOAD: `carry`=0.
  - `zero` = (written value == 0).
- `src_a`, `src_b` and `dst` may be equal. Both reads complete before the write, so a write never corrupts its own operands.

## Timing
- Start accepted in cycle 0. Then RD_A is cycle 1, RD_B cycle 2, EXEC cycle 3, WB cycle 4, DONE cycle 5, and IDLE returns in cycle 6.
- LOAD: WB is cycle 1, DONE cycle 2.
- Register-file read latency is 1 cycle: an address driven with `we`=0 in cycle N appears on `rf_rdata` in cycle N+1.
- Back-to-back throughput is one command per 6 cycles (3 for LOAD).
- `rf_we` is high for exactly one cycle per command.

## Configuration
- `RF_SEQ_READBACK_EN` defined: after WB, two extra states run before DONE. Non-LOAD commands therefore end with DONE in cycle 7.
  - VFY_RD: `rf_addr`=`dst`, `rf_we`=0.
  - VFY_CMP: `rf_addr`=`dst`, `rf_we`=0; compare `rf_rdata` with `result`. Set `mismatch` on inequality, clear it on equality; it holds until the next compare.
- Not defined: WB goes directly to DONE, and `mismatch` is tied to 0.

## Structure
- Package `rf_seq_pkg` holds the opcode constants, the state encoding (IDLE, RD_A, RD_B, EXEC, WB, DONE, VFY_RD, VFY_CMP) and the DATA_W/ADDR_W defaults.
- Sub-module `ula_core` is combinational: (a, b, op) → (y, carry).
- The FSM, operand registers and output registers live in `rf_op_sequencer`.

## Test plan
- LOAD R1=3, then LOAD R2=5 → `rf_we` pulses in cycle 1 each time, `done` in cycle 2, `result`=3 then 5.
- ADD src 1,2 → dst 3 → R3=8, `carry`=0, `zero`=0. `rf_addr` sequence 1,2,3,3; `done` in cycle 5.
- SUB 3−5 → dst 0 → R0=0xE, `carry`=0. ADD 0xF+0x1 → result 0, `carry`=1, `zero`=1.
- `start` held high for 10 cycles → exactly two commands execute, accepted in cycles 0 and 6.
- `reset`=0 asserted in EXEC → next cycle all outputs 0, `dst` register unchanged, and a new `start` is accepted after release.
- With `RF_SEQ_READBACK_EN`: the bench model returns a corrupted value in VFY_CMP → `mismatch`=1 and `done` in cycle 7. With a correct model, `mismatch`=0.
